// File: rtl/task_dispatcher.sv
// Task work-queue: per-core holding registers and a host launch port feed a FIFO of
// queue numbers, which are dispatched round-robin to requesting cores as start PCs.
module task_dispatcher #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CORES-1:0]     queue_wen,
    input  logic [4*NUM_CORES-1:0]   queue_number,
    input  logic [NUM_CORES-1:0]     request_new_pc,
    output logic [16*NUM_CORES-1:0]  new_pc,
    output logic [2*NUM_CORES-1:0]   idle,
    input  logic                     cfg_wen,
    input  logic [3:0]               cfg_idx,
    input  logic [15:0]              cfg_pc,
    input  logic                     launch_valid,
    input  logic [3:0]               launch_queue,
    output logic                     launch_ready,
    output logic                     all_done,
    output logic                     overflow
);

    localparam int unsigned CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(DEPTH + 1);

    logic [NUM_CORES-1:0]    hv_q, hv_d;
    logic [3:0]              hold_q [NUM_CORES];
    logic [3:0]              hold_d [NUM_CORES];
    logic [3:0]              fifo_q [DEPTH];
    logic [3:0]              fifo_d [DEPTH];
    logic [15:0]             table_q [16];
    logic [15:0]             table_d [16];
    logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           ph_q, ph_d, pg_q, pg_d;
    logic [NUM_CORES-1:0]    pend_q, pend_d;
    logic [16*NUM_CORES-1:0] new_pc_q, new_pc_d;
    logic [2*NUM_CORES-1:0]  idle_q, idle_d;
    logic                    all_done_q, all_done_d;
    logic                    ovf_q, ovf_d;
    logic                    run_q;

    logic                    full, empty;
    logic                    ph_any, pg_any;
    logic [CW-1:0]           ph_win, pg_win, ph_idx, pg_idx;
    logic                    push_hold, push_launch, fifo_push, pop;
    logic [3:0]              push_data;
    logic [15:0]             head_pc;

    assign full  = (cnt_q == NW'(DEPTH));
    assign empty = (cnt_q == '0);

    // Round-robin pick of the occupied holding register, starting at ph_q
    always_comb begin
        ph_any = 1'b0;
        ph_win = '0;
        ph_idx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            ph_idx = CW'((32'(ph_q) + k) % NUM_CORES);
            if (!ph_any && hv_q[ph_idx]) begin
                ph_any = 1'b1;
                ph_win = ph_idx;
            end
        end
    end

    // Round-robin pick of the pending core to grant, starting at pg_q
    always_comb begin
        pg_any = 1'b0;
        pg_win = '0;
        pg_idx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            pg_idx = CW'((32'(pg_q) + k) % NUM_CORES);
            if (!pg_any && pend_q[pg_idx]) begin
                pg_any = 1'b1;
                pg_win = pg_idx;
            end
        end
    end

    // launch_ready is held low for the first cycle out of reset
    assign launch_ready = run_q && !full && !(|hv_q);
    assign push_hold    = ph_any && !full;
    assign push_launch  = launch_ready && launch_valid;
    assign fifo_push    = push_hold || push_launch;
    assign push_data    = push_hold ? hold_q[ph_win] : launch_queue;
    assign pop          = pg_any && !empty;
    assign head_pc      = table_q[fifo_q[rp_q]];

    always_comb begin
        hv_d       = hv_q;
        hold_d     = hold_q;
        fifo_d     = fifo_q;
        table_d    = table_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        cnt_d      = cnt_q + NW'(fifo_push) - NW'(pop);
        ph_d       = ph_q;
        pg_d       = pg_q;
        pend_d     = pend_q;
        new_pc_d   = new_pc_q;
        idle_d     = idle_q;
        ovf_d      = ovf_q;
        all_done_d = 1'b0;

        if (cfg_wen) begin
            table_d[cfg_idx] = cfg_pc;
        end

        if (push_hold) begin
            hv_d[ph_win] = 1'b0;
            ph_d         = CW'((32'(ph_win) + 32'd1) % NUM_CORES);
        end
        if (fifo_push) begin
            fifo_d[wp_q] = push_data;
            wp_d         = AW'(wp_q + 1'b1);
        end
        if (pop) begin
            rp_d = AW'(rp_q + 1'b1);
            pg_d = CW'((32'(pg_win) + 32'd1) % NUM_CORES);
        end

        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            // A push into a register that drains this same edge is accepted
            if (queue_wen[i]) begin
                if (!hv_q[i] || (push_hold && ph_win == CW'(i))) begin
                    hv_d[i]   = 1'b1;
                    hold_d[i] = queue_number[4*i +: 4];
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (pop && pg_win == CW'(i)) begin
                pend_d[i]            = 1'b0;
                new_pc_d[16*i +: 16] = head_pc;
            end
            if (request_new_pc[i]) begin
                pend_d[i] = 1'b1;
            end
        end

        all_done_d = (&pend_q) && empty && !(|hv_q) && !(|queue_wen) && !launch_valid;

        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idle_d[2*i +: 2] = all_done_d ? 2'b10 : (pend_d[i] ? 2'b01 : 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            ph_q       <= '0;
            pg_q       <= '0;
            pend_q     <= '1;
            new_pc_q   <= '0;
            all_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            run_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                hold_q[i]         <= '0;
                idle_q[2*i +: 2]  <= 2'b01;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 16; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            hv_q       <= hv_d;
            hold_q     <= hold_d;
            fifo_q     <= fifo_d;
            table_q    <= table_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            pg_q       <= pg_d;
            pend_q     <= pend_d;
            new_pc_q   <= new_pc_d;
            idle_q     <= idle_d;
            all_done_q <= all_done_d;
            ovf_q      <= ovf_d;
            run_q      <= 1'b1;
        end
    end

    assign new_pc   = new_pc_q;
    assign idle     = idle_q;
    assign all_done = all_done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Scenario bench for task_dispatcher: expected grants are queued as stimulus is driven
// and matched by a monitor whenever a core's status drops to "task delivered".
module tb_task_dispatcher;

    localparam int unsigned NC = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   queue_wen;
    logic [4*NC-1:0] queue_number;
    logic [NC-1:0]   request_new_pc;
    logic [16*NC-1:0] new_pc;
    logic [2*NC-1:0] idle;
    logic            cfg_wen;
    logic [3:0]      cfg_idx;
    logic [15:0]     cfg_pc;
    logic            launch_valid;
    logic [3:0]      launch_queue;
    logic            launch_ready;
    logic            all_done;
    logic            overflow;

    always #5 clk = ~clk;

    task_dispatcher #(.NUM_CORES(NC), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .queue_wen(queue_wen), .queue_number(queue_number),
        .request_new_pc(request_new_pc), .new_pc(new_pc), .idle(idle),
        .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
        .launch_valid(launch_valid), .launch_queue(launch_queue),
        .launch_ready(launch_ready), .all_done(all_done), .overflow(overflow)
    );

    typedef struct packed {
        logic [1:0]  core;
        logic [15:0] pc;
    } grant_t;

    grant_t          exp_q[$];
    grant_t          mon_e;
    int              n_checks = 0;
    int              n_pass   = 0;
    logic [2*NC-1:0] prev_idle;

    // Grant monitor: a core moving from waiting/drained to 00 received a task
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rst_n === 1'b1 && prev_idle[2*i +: 2] != 2'b00 && idle[2*i +: 2] == 2'b00) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_grant core %0d pc %h, required no grant", i, new_pc[16*i +: 16]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.core !== 2'(i) || mon_e.pc !== new_pc[16*i +: 16])
                        $display("FAIL grant got core %0d pc %h, required core %0d pc %h",
                                 i, new_pc[16*i +: 16], mon_e.core, mon_e.pc);
                    else
                        n_pass++;
                end
            end
        end
        prev_idle = idle;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        queue_wen = '0; queue_number = '0; request_new_pc = '0;
        cfg_wen = 1'b0; cfg_idx = '0; cfg_pc = '0;
        launch_valid = 1'b0; launch_queue = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [15:0] pc);
        cfg_wen = 1'b1; cfg_idx = idx; cfg_pc = pc;
        step(1);
        cfg_wen = 1'b0;
    endtask

    task automatic do_launch(input logic [3:0] q);
        int n;
        n = 0;
        launch_valid = 1'b1;
        launch_queue = q;
        while (!launch_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            $display("FAIL launch_timeout queue %0d ready %b, required 1", q, launch_ready);
        end
        @(negedge clk);
        launch_valid = 1'b0;
    endtask

    task automatic expect_grant(input int core, input logic [15:0] pc);
        grant_t g;
        g.core = 2'(core);
        g.pc   = pc;
        exp_q.push_back(g);
    endtask

    task automatic check_sb_empty(input string tag);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_missing_grants got %0d outstanding, required 0", tag, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        step(1);
        n_checks++;
        if (new_pc !== '0 || idle !== 8'h55 || all_done !== 1'b0 || overflow !== 1'b0 || launch_ready !== 1'b0)
            $display("FAIL reset_values got pc=%h idle=%h done=%b ovf=%b rdy=%b, required 0/55/0/0/0",
                     new_pc, idle, all_done, overflow, launch_ready);
        else n_pass++;
        rst_n = 1'b1;
        step(1);
        n_checks++;
        if (launch_ready !== 1'b1 || all_done !== 1'b1 || idle !== 8'hAA)
            $display("FAIL post_reset got rdy=%b done=%b idle=%h, required 1/1/aa", launch_ready, all_done, idle);
        else n_pass++;
    endtask

    task automatic test_single_launch();
        apply_reset();
        cfg_write(4'd3, 16'h0040);
        expect_grant(0, 16'h0040);
        do_launch(4'd3);
        n_checks++;
        if (idle !== 8'h55 || all_done !== 1'b0)
            $display("FAIL single_queued got idle=%h done=%b, required 55/0", idle, all_done);
        else n_pass++;
        step(1);
        n_checks++;
        if (new_pc[15:0] !== 16'h0040 || idle !== 8'h54)
            $display("FAIL single_grant got pc0=%h idle=%h, required 0040/54", new_pc[15:0], idle);
        else n_pass++;
        step(2);
        check_sb_empty("single");
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int q = 1; q <= 4; q++) cfg_write(4'(q), 16'h0100 + 16'(q));
        for (int q = 1; q <= 4; q++) begin
            expect_grant(q - 1, 16'h0100 + 16'(q));
            do_launch(4'(q));
        end
        step(3);
        check_sb_empty("rr");
        step(4);
        n_checks++;
        if (all_done !== 1'b0 || idle !== 8'h00)
            $display("FAIL rr_busy got done=%b idle=%h, required 0/00", all_done, idle);
        else n_pass++;
        request_new_pc = 4'hF;
        step(1);
        request_new_pc = '0;
        step(1);
        n_checks++;
        if (all_done !== 1'b1 || idle !== 8'hAA)
            $display("FAIL rr_drain got done=%b idle=%h, required 1/aa", all_done, idle);
        else n_pass++;
    endtask

    task automatic test_core_push();
        apply_reset();
        cfg_write(4'd5, 16'h0500);
        cfg_write(4'd6, 16'h0600);
        expect_grant(0, 16'h0500);
        expect_grant(1, 16'h0600);
        queue_wen    = 4'b0101;
        queue_number = 16'h0605;
        step(1);
        queue_wen = '0;
        n_checks++;
        if (launch_ready !== 1'b0) $display("FAIL push_ready_both got %b, required 0", launch_ready);
        else n_pass++;
        step(1);
        n_checks++;
        if (launch_ready !== 1'b0) $display("FAIL push_ready_one got %b, required 0", launch_ready);
        else n_pass++;
        step(1);
        n_checks++;
        if (launch_ready !== 1'b1) $display("FAIL push_ready_drained got %b, required 1", launch_ready);
        else n_pass++;
        step(3);
        check_sb_empty("push");
    endtask

    task automatic test_overflow();
        apply_reset();
        cfg_write(4'd2, 16'h0200);
        cfg_write(4'd9, 16'h0900);
        for (int i = 0; i < 4; i++) begin
            expect_grant(i, 16'h0200);
            do_launch(4'd2);
        end
        step(3);
        for (int i = 0; i < 8; i++) do_launch(4'd9);
        n_checks++;
        if (launch_ready !== 1'b0 || overflow !== 1'b0)
            $display("FAIL full_state got rdy=%b ovf=%b, required 0/0", launch_ready, overflow);
        else n_pass++;
        queue_wen    = 4'b0010;
        queue_number = 16'h00A0;
        step(1);
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_first_push got %b, required 0", overflow);
        else n_pass++;
        step(1);
        queue_wen = '0;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_drop got %b, required 1", overflow);
        else n_pass++;
        expect_grant(0, 16'h0900);
        request_new_pc = 4'b0001;
        step(1);
        request_new_pc = '0;
        step(4);
        n_checks++;
        if (overflow !== 1'b1 || launch_ready !== 1'b0)
            $display("FAIL ovf_sticky got ovf=%b rdy=%b, required 1/0", overflow, launch_ready);
        else n_pass++;
        check_sb_empty("ovf");
    endtask

    task automatic test_drain();
        apply_reset();
        cfg_write(4'd7, 16'h0700);
        request_new_pc = 4'hF;
        step(1);
        request_new_pc = '0;
        step(1);
        n_checks++;
        if (all_done !== 1'b1 || idle !== 8'hAA)
            $display("FAIL drain_done got done=%b idle=%h, required 1/aa", all_done, idle);
        else n_pass++;
        expect_grant(0, 16'h0700);
        do_launch(4'd7);
        n_checks++;
        if (all_done !== 1'b0 || idle !== 8'h55)
            $display("FAIL drain_wake got done=%b idle=%h, required 0/55", all_done, idle);
        else n_pass++;
        step(1);
        n_checks++;
        if (new_pc[15:0] !== 16'h0700) $display("FAIL drain_grant got %h, required 0700", new_pc[15:0]);
        else n_pass++;
        step(2);
        check_sb_empty("drain");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int q = 1; q <= 7; q++) cfg_write(4'(q), 16'h0100 + 16'(q));
        for (int q = 1; q <= 7; q++) begin
            if (q <= 4) expect_grant(q - 1, 16'h0100 + 16'(q));
            do_launch(4'(q));
        end
        step(1);
        check_sb_empty("midrst_pre");
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (new_pc !== '0 || idle !== 8'h55 || all_done !== 1'b0 || overflow !== 1'b0 || launch_ready !== 1'b0)
            $display("FAIL midrst_values got pc=%h idle=%h done=%b ovf=%b rdy=%b, required 0/55/0/0/0",
                     new_pc, idle, all_done, overflow, launch_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        n_checks++;
        if (all_done !== 1'b1 || idle !== 8'hAA)
            $display("FAIL midrst_empty got done=%b idle=%h, required 1/aa", all_done, idle);
        else n_pass++;
        step(3);
        check_sb_empty("midrst_post");
    endtask

    initial begin
        test_reset();
        test_single_launch();
        test_round_robin();
        test_core_push();
        test_overflow();
        test_drain();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/task_dispatcher.md
Name: task_dispatcher

Overview:
- Work-queue end of the processor's task protocol: accepts task pushes from NUM_CORES processor cores (queue_wen/queue_number) and from a host launch port.
- Buffers the queue numbers in a FIFO.
- Answers each core's request_new_pc by mapping a dequeued queue number to a start PC (new_pc) and signalling status on idle.
- Sits between the cores and the GPU top level; the top level programs the PC table and seeds the first task.

Parameters:
NUM_CORES, 4, number of processor cores served
DEPTH, 8, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
queue_wen  in  NUM_CORES  per-core task push strobe
queue_number  in  4*NUM_CORES  per-core queue number, core i at [4i+3:4i]
request_new_pc  in  NUM_CORES  per-core request for a new task
new_pc  out  16*NUM_CORES  per-core start PC, core i at [16i+15:16i]
idle  out  2*NUM_CORES  per-core status: 00 task delivered/running, 01 waiting, 10 drained
cfg_wen  in  1  PC table write enable
cfg_idx  in  4  PC table index
cfg_pc  in  16  PC table write data
launch_valid  in  1  host task push request
launch_queue  in  4  host queue number
launch_ready  out  1  host push accepted this cycle when high with launch_valid
all_done  out  1  every core waiting, FIFO and holding registers empty
overflow  out  1  sticky: a core push was dropped

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous active-low.
- Reset values:
  - new_pc = 0; idle = 01 for every core; pending[i] = 1 for all cores, since cores leave reset requesting work.
  - FIFO empty; holding registers empty; round-robin pointers = 0.
  - overflow = 0; all_done = 0; launch_ready = 0; PC table all zero.
  - Reset mid-operation discards all queued tasks and pending grants.
- PC table: 16 x 16-bit entries.
  - Written on the clock edge when cfg_wen=1.
  - A write takes effect for grants on the following edge and later.
- Core push path:
  - Each core has a one-entry holding register.
  - queue_wen[i]=1 with holding[i] empty loads queue_number[i] at the edge.
  - queue_wen[i]=1 with holding[i] occupied drops the push and sets overflow=1 until reset.
  - A push while holding[i] drains at that same edge is accepted, not dropped.
- FIFO fill:
  - At most one FIFO push per cycle.
  - Occupied holding registers are drained first, selected round-robin starting at push pointer ph; ph then moves to the winner+1 (mod NUM_CORES).
  - Launch is served only when no holding register is occupied and the FIFO is not full.
  - launch_ready is combinational: !full && no holding occupied.
  - No push while the FIFO is full; holding registers stall.
- Requests:
  - request_new_pc[i]=1 sampled at an edge sets pending[i] and idle[i]=01 at that edge.
  - A request while already pending has no extra effect.
- Dispatch:
  - Each cycle, if the FIFO is non-empty and any pending bit is set, grant exactly one core.
  - Winner is chosen round-robin from grant pointer pg; pg then moves to the winner+1.
  - At the edge: pop the FIFO head q; new_pc[w] = table[q]; idle[w] = 00; pending[w] cleared.
  - new_pc[w] holds until that core's next grant.
  - Minimum latency from request sampled to idle=00 is one edge (pending set at edge t, grant at edge t+1).
- FIFO ordering:
  - Pop sees registered contents only; an entry pushed at edge t is poppable from edge t+1.
  - Simultaneous push and pop when full is not possible, since a full FIFO blocks the push.
  - Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- Drain:
  - all_done is registered and goes high at the edge after all of these are true: all pending set, FIFO empty, all holding empty, no queue_wen or launch_valid asserted.
  - While all_done=1, idle = 10 for every core.
  - Any push clears all_done at the next edge; waiting cores then show 01.
- Simultaneous events on one core: request_new_pc[i] and queue_wen[i] in the same cycle are processed independently.

Test Plan:
- Reset, then table[3]=16'h0040, launch_queue=3 → FIFO holds 3; next edge core0 gets new_pc=16'h0040, idle0=00; cores 1–3 stay idle=01.
- All cores pending; launch 1,2,3,4 with table[n]=16'h0100+n → grants go to cores 0,1,2,3 in order with PCs 0101..0104, then all_done stays 0 until every core requests again.
- Cores 0 and 2 pulse queue_wen the same cycle with values 5 and 6 → FIFO order 5 then 6; launch_ready=0 until both holding registers drain.
- Fill the FIFO with 8 launches and no pending cores → launch_ready=0. Core1 pushes twice while stalled → second push dropped, overflow=1 and sticky.
- All four cores request and the FIFO is empty → all_done=1 and idle=10 for all cores. Then launch queue 7 → all_done=0 next edge and core0 receives table[7].
- Assert rst_n low mid-dispatch with 3 entries queued → outputs return to reset values immediately, FIFO empty after release.
